// File: rtl/gamepad_pkg.sv
// Shared bit/slot indices for the gamepad-to-arcade button mapper.
// Input indices follow the usb_gamepad_module byte; slots follow the I_BUTTON layout.
package gamepad_pkg;

    localparam int unsigned PAD_A      = 0;
    localparam int unsigned PAD_B      = 1;
    localparam int unsigned PAD_SELECT = 2;
    localparam int unsigned PAD_START  = 3;
    localparam int unsigned PAD_UP     = 4;
    localparam int unsigned PAD_DOWN   = 5;
    localparam int unsigned PAD_LEFT   = 6;
    localparam int unsigned PAD_RIGHT  = 7;

    localparam int unsigned SLOT_UP    = 0;
    localparam int unsigned SLOT_DOWN  = 1;
    localparam int unsigned SLOT_LEFT  = 2;
    localparam int unsigned SLOT_RIGHT = 3;
    localparam int unsigned SLOT_FIRE  = 4;
    localparam int unsigned SLOT_SPARE = 5;
    localparam int unsigned SLOT_COIN  = 6;
    localparam int unsigned SLOT_START = 7;

    // START high-active; COIN, FIRE and directions low-active.
    localparam logic [7:0] DEFAULT_ACTIVE_LOW_MASK = 8'b0101_1111;

endpackage

// File: rtl/gamepad_channel.sv
// One pad: report capture, per-bit debounce, disconnect watchdog, autofire and coin pulse.
// Produces registered logical (active-high) buttons in slot order.
module gamepad_channel
    import gamepad_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES   = 2,
    parameter int unsigned TIMEOUT       = 2400000,
    parameter int unsigned AUTOFIRE_HALF = 1200000,
    parameter int unsigned COIN_PULSE    = 240000
) (
    input  logic       Clk,
    input  logic       I_nRESET,
    input  logic [7:0] pad_data,
    input  logic       pad_ena,
    input  logic       autofire_en,
    output logic [7:0] buttons,
    output logic       pad_alive
);

    localparam int unsigned DEB_W  = $clog2(DEB_SAMPLES + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned AF_W   = $clog2(AUTOFIRE_HALF + 1);
    localparam int unsigned COIN_W = $clog2(COIN_PULSE + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_SAMPLES);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [AF_W-1:0]   AF_LAST  = AF_W'(AUTOFIRE_HALF - 1);
    localparam logic [COIN_W-1:0] COIN_MAX = COIN_W'(COIN_PULSE);

    logic [7:0]            cap_q, cap_d;
    logic [7:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [7:0]            acc_q, acc_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  alive_q, alive_d;
    logic                  phase_q, phase_d;
    logic [AF_W-1:0]       af_cnt_q, af_cnt_d;
    logic [COIN_W-1:0]     coin_cnt_q, coin_cnt_d;
    logic [7:0]            buttons_q, buttons_d;
    logic                  expire;

    always_ff @(posedge Clk) begin
        if (!I_nRESET) begin
            cap_q      <= '0;
            deb_cnt_q  <= '0;
            acc_q      <= '0;
            wd_q       <= '0;
            alive_q    <= 1'b0;
            phase_q    <= 1'b0;
            af_cnt_q   <= '0;
            coin_cnt_q <= '0;
            buttons_q  <= '0;
        end else begin
            cap_q      <= cap_d;
            deb_cnt_q  <= deb_cnt_d;
            acc_q      <= acc_d;
            wd_q       <= wd_d;
            alive_q    <= alive_d;
            phase_q    <= phase_d;
            af_cnt_q   <= af_cnt_d;
            coin_cnt_q <= coin_cnt_d;
            buttons_q  <= buttons_d;
        end
    end

    always_comb begin
        cap_d      = cap_q;
        deb_cnt_d  = deb_cnt_q;
        acc_d      = acc_q;
        wd_d       = wd_q;
        phase_d    = phase_q;
        af_cnt_d   = af_cnt_q;
        coin_cnt_d = coin_cnt_q;

        if (pad_ena) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
        // A strobe in the expiry cycle clears the counter, so it always wins.
        expire  = !pad_ena && (wd_d == WD_MAX);
        alive_d = pad_ena ? 1'b1 : (expire ? 1'b0 : alive_q);

        if (pad_ena) begin
            cap_d = pad_data;
            for (int b = 0; b < 8; b++) begin
                if (pad_data[b] == cap_q[b]) begin
                    if (deb_cnt_q[b] != DEB_MAX) deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end else begin
                    deb_cnt_d[b] = DEB_W'(1);
                end
                if (deb_cnt_d[b] == DEB_MAX) acc_d[b] = pad_data[b];
            end
        end

        if (expire) begin
            cap_d     = '0;
            deb_cnt_d = '0;
            acc_d     = '0;
        end

        // B press starts in the firing phase so the first accepted cycle fires.
        if (acc_d[PAD_B] && !acc_q[PAD_B]) begin
            phase_d  = 1'b1;
            af_cnt_d = '0;
        end else if (acc_d[PAD_B]) begin
            if (af_cnt_q == AF_LAST) begin
                phase_d  = !phase_q;
                af_cnt_d = '0;
            end else begin
                af_cnt_d = af_cnt_q + 1'b1;
            end
        end else begin
            phase_d  = 1'b0;
            af_cnt_d = '0;
        end

        if (expire) begin
            coin_cnt_d = '0;
        end else if (coin_cnt_q != '0) begin
            coin_cnt_d = coin_cnt_q - 1'b1;
        end else if (acc_d[PAD_SELECT] && !acc_q[PAD_SELECT]) begin
            coin_cnt_d = COIN_MAX;
        end
    end

    always_comb begin
        buttons_d             = '0;
        buttons_d[SLOT_UP]    = acc_q[PAD_UP];
        buttons_d[SLOT_DOWN]  = acc_q[PAD_DOWN];
        buttons_d[SLOT_LEFT]  = acc_q[PAD_LEFT];
        buttons_d[SLOT_RIGHT] = acc_q[PAD_RIGHT];
        buttons_d[SLOT_FIRE]  = acc_q[PAD_A] | (autofire_en & acc_q[PAD_B] & phase_q);
        buttons_d[SLOT_SPARE] = 1'b0;
        buttons_d[SLOT_COIN]  = (coin_cnt_q != '0);
        buttons_d[SLOT_START] = acc_q[PAD_START];
    end

    assign buttons   = buttons_q;
    assign pad_alive = alive_q;

endmodule

// File: rtl/gamepad_button_mapper.sv
// Maps N_PADS USB gamepad reports onto per-player I_BUTTON vectors,
// applying the per-slot output polarity mask.
module gamepad_button_mapper
    import gamepad_pkg::*;
#(
    parameter int unsigned N_PADS          = 2,
    parameter int unsigned DEB_SAMPLES     = 2,
    parameter int unsigned TIMEOUT         = 2400000,
    parameter int unsigned AUTOFIRE_HALF   = 1200000,
    parameter int unsigned COIN_PULSE      = 240000,
    parameter logic [7:0]  ACTIVE_LOW_MASK = DEFAULT_ACTIVE_LOW_MASK
) (
    input  logic                Clk,
    input  logic                I_nRESET,
    input  logic [8*N_PADS-1:0] pad_data,
    input  logic [N_PADS-1:0]   pad_ena,
    input  logic [N_PADS-1:0]   autofire_en,
    output logic [8*N_PADS-1:0] btn_out,
    output logic [N_PADS-1:0]   pad_alive
);

    for (genvar i = 0; i < N_PADS; i++) begin : g_pad
        logic [7:0] buttons;

        gamepad_channel #(
            .DEB_SAMPLES  (DEB_SAMPLES),
            .TIMEOUT      (TIMEOUT),
            .AUTOFIRE_HALF(AUTOFIRE_HALF),
            .COIN_PULSE   (COIN_PULSE)
        ) u_channel (
            .Clk        (Clk),
            .I_nRESET   (I_nRESET),
            .pad_data   (pad_data[8*i +: 8]),
            .pad_ena    (pad_ena[i]),
            .autofire_en(autofire_en[i]),
            .buttons    (buttons),
            .pad_alive  (pad_alive[i])
        );

        assign btn_out[8*i +: 8] = buttons ^ ACTIVE_LOW_MASK;
    end

endmodule

// File: tb/tb_gamepad_button_mapper.sv
// Directed bench for gamepad_button_mapper: two pads, short timer parameters,
// expected button bytes computed by hand from the default polarity mask.
module tb_gamepad_button_mapper;

    localparam int unsigned T    = 5000;
    localparam int unsigned HALF = 100;
    localparam int unsigned COIN = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pad_data;
    logic [1:0]  pad_ena;
    logic [1:0]  autofire_en;
    logic [15:0] btn_out;
    logic [1:0]  pad_alive;

    int n_cmp = 0;
    int n_err = 0;

    logic mon_en = 1'b0;
    int   low_cnt;
    int   pulses;
    logic prev_coin;

    gamepad_button_mapper #(
        .N_PADS         (2),
        .DEB_SAMPLES    (2),
        .TIMEOUT        (T),
        .AUTOFIRE_HALF  (HALF),
        .COIN_PULSE     (COIN),
        .ACTIVE_LOW_MASK(8'b0101_1111)
    ) dut (
        .Clk        (clk),
        .I_nRESET   (rst_n),
        .pad_data   (pad_data),
        .pad_ena    (pad_ena),
        .autofire_en(autofire_en),
        .btn_out    (btn_out),
        .pad_alive  (pad_alive)
    );

    always #5 clk = ~clk;

    // Measures pad 0 COIN slot (active-low): low cycles and number of pulses.
    always @(negedge clk) begin
        if (!mon_en) begin
            low_cnt   <= 0;
            pulses    <= 0;
            prev_coin <= 1'b1;
        end else begin
            if (!btn_out[6]) low_cnt <= low_cnt + 1;
            if (!btn_out[6] && prev_coin) pulses <= pulses + 1;
            prev_coin <= btn_out[6];
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one strobe on pad 0; the k-th negedge afterwards is cycle t+k.
    task automatic strobe(input logic [7:0] d);
        @(posedge clk);
        #1;
        pad_data[7:0] = d;
        pad_ena[0]    = 1'b1;
        @(posedge clk);
        #1;
        pad_ena[0] = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pad_data    = '0;
        pad_ena     = '0;
        autofire_en = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        tick(1);
        check("reset_btn", btn_out, 16'h5F5F);
        check("reset_alive", {14'd0, pad_alive}, 16'h0000);
        tick(T + 10);
        check("idle_btn", btn_out, 16'h5F5F);
        check("idle_alive", {14'd0, pad_alive}, 16'h0000);

        // Debounce: UP accepted only on the second matching report.
        strobe(8'h10);
        tick(1);
        check("first_strobe_alive", {14'd0, pad_alive}, 16'h0001);
        tick(1);
        check("deb_single_hold", btn_out, 16'h5F5F);
        tick(998);
        strobe(8'h10);
        tick(1);
        check("deb_k1", btn_out, 16'h5F5F);
        tick(1);
        check("deb_k2_up", btn_out, 16'h5F5E);
        strobe(8'h00);
        tick(10);
        strobe(8'h00);
        tick(2);
        check("up_release", btn_out, 16'h5F5F);
        strobe(8'h10);
        tick(20);
        check("glitch_a", btn_out, 16'h5F5F);
        strobe(8'h00);
        tick(20);
        check("glitch_b", btn_out, 16'h5F5F);

        // Autofire: fire asserted for HALF cycles, then released for HALF.
        autofire_en = 2'b01;
        strobe(8'h02);
        tick(2398);
        strobe(8'h02);
        tick(2);
        check("af_k2", btn_out, 16'h5F4F);
        tick(99);
        check("af_k101", btn_out, 16'h5F4F);
        tick(1);
        check("af_k102", btn_out, 16'h5F5F);
        tick(99);
        check("af_k201", btn_out, 16'h5F5F);
        tick(1);
        check("af_k202", btn_out, 16'h5F4F);
        autofire_en = 2'b00;
        tick(3);
        check("af_off_a", btn_out, 16'h5F5F);
        tick(45);
        check("af_off_b", btn_out, 16'h5F5F);
        strobe(8'h00);
        tick(10);
        strobe(8'h00);
        tick(2);
        check("b_release", btn_out, 16'h5F5F);

        // Coin: SELECT held for 5*COIN cycles gives one COIN-cycle pulse.
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            strobe(8'h04);
            tick(48);
        end
        tick(1);
        #1;
        check("coin1_len", low_cnt[15:0], 16'(COIN));
        check("coin1_pulses", pulses[15:0], 16'd1);
        mon_en = 1'b0;
        strobe(8'h00);
        tick(10);
        strobe(8'h00);
        tick(10);
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(8'h04);
            tick(48);
        end
        tick(100);
        #1;
        check("coin2_len", low_cnt[15:0], 16'(COIN));
        check("coin2_pulses", pulses[15:0], 16'd1);
        mon_en = 1'b0;

        // Watchdog: A+RIGHT held, then reports stop.
        strobe(8'h81);
        tick(10);
        strobe(8'h81);
        tick(2);
        check("hold_81", btn_out, 16'h5F47);
        tick(T - 2);
        check("wd_kT_alive", {14'd0, pad_alive}, 16'h0001);
        tick(1);
        check("wd_kT1_alive", {14'd0, pad_alive}, 16'h0000);
        check("wd_kT1_btn", btn_out, 16'h5F47);
        tick(1);
        check("wd_kT2_btn", btn_out, 16'h5F5F);

        // Strobe landing in the expiry cycle keeps the pad alive.
        strobe(8'h81);
        tick(1);
        check("revive_alive", {14'd0, pad_alive}, 16'h0001);
        tick(T - 2);
        strobe(8'h81);
        tick(1);
        check("coinc_alive", {14'd0, pad_alive}, 16'h0001);
        tick(1);
        check("coinc_btn", btn_out, 16'h5F47);
        tick(100);
        check("coinc_alive_later", {14'd0, pad_alive}, 16'h0001);

        // Reset during a coin pulse.
        strobe(8'h04);
        tick(10);
        strobe(8'h04);
        tick(2);
        check("coin3_active", btn_out, 16'h5F1F);
        tick(50);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        check("rst_mid_btn", btn_out, 16'h5F5F);
        check("rst_mid_alive", {14'd0, pad_alive}, 16'h0000);
        tick(400);
        check("rst_no_resume", btn_out, 16'h5F5F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
